// File: rtl/ahb_burst_master_pkg.sv
// Shared AHB-Lite encodings and burst helpers for the burst master and its address generator.
package ahb_burst_master_pkg;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } type_hsize;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } type_hburst;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } type_htrans;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } type_hresp;

    localparam logic [9:0] AHB_1KB_MASK = 10'h3FF;

    // Fixed-length beat count; INCR length comes from the command instead.
    function automatic logic [4:0] burst_beats(type_hburst hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
            HBURST_WRAP16, HBURST_INCR16: return 5'd16;
            default:                      return 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_burst_master_if.sv
// AHB-Lite master/slave signal bundle.
interface ahb_burst_master_if
    import ahb_burst_master_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] HADDR;
    type_hburst        HBURST;
    type_hsize         HSIZE;
    type_htrans        HTRANS;
    logic              HWRITE;
    logic [DATA_W-1:0] HWDATA;
    logic [6:0]        HPROT;
    logic              HMASTLOCK;
    logic              HREADY;
    type_hresp         HRESP;
    logic [DATA_W-1:0] HRDATA;

    modport master (
        output HADDR, HBURST, HSIZE, HTRANS, HWRITE, HWDATA, HPROT, HMASTLOCK,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        input  HADDR, HBURST, HSIZE, HTRANS, HWRITE, HWDATA, HPROT, HMASTLOCK,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_burst_master_addr_gen.sv
// Combinational next-beat address: linear or wrapping increment plus 1 KB crossing detect.
module ahb_burst_master_addr_gen
    import ahb_burst_master_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CW     = 5
) (
    input  logic [ADDR_W-1:0] addr,
    input  type_hsize         size,
    input  type_hburst        burst,
    input  logic [CW-1:0]     beats,
    output logic [ADDR_W-1:0] next_addr,
    output logic              cross_1k
);
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_mask;
    logic              is_wrap;

    assign is_wrap   = (burst == HBURST_WRAP4) || (burst == HBURST_WRAP8) ||
                       (burst == HBURST_WRAP16);
    assign inc       = ADDR_W'(1) << size;
    assign incr_addr = addr + inc;
    assign wrap_mask = (ADDR_W'(beats) << size) - ADDR_W'(1);
    assign next_addr = is_wrap ? ((addr & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;
    // Wrapping bursts never leave their aligned window, so only linear bursts split.
    assign cross_1k  = !is_wrap && ((next_addr[9:0] & AHB_1KB_MASK) == 10'd0);
endmodule

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: one command per handshake, pipelined address/data, 1 KB split, ERROR abort.
module ahb_burst_master
    import ahb_burst_master_pkg::*;
#(
    parameter int  DATA_W  = 32,
    parameter int  ADDR_W  = 32,
    parameter int  MAX_LEN = 16,
    localparam int CW      = $clog2(MAX_LEN + 1)
) (
    input  logic               HCLK,
    input  logic               HRESETN,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  type_hsize          cmd_size,
    input  type_hburst         cmd_burst,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [CW-1:0]      cmd_len,
    output logic               wr_ren,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               rd_wen,
    output logic [DATA_W-1:0]  rd_data,
    output logic               done,
    output logic               done_err,
    output logic [CW-1:0]      done_beats,
    ahb_burst_master_if.master ahb
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR} state_t;

    state_t            state;
    type_hburst        burst_q;
    logic [CW-1:0]     beats_q;
    logic [CW-1:0]     addr_left;
    logic [CW-1:0]     beat_cnt;
    logic [CW-1:0]     cmd_beats;
    logic              data_pend;
    logic [ADDR_W-1:0] next_addr;
    logic              cross_1k;
    logic              addr_acc;
    logic              data_ok;
    logic              data_err;

    always_comb begin
        cmd_beats = CW'(burst_beats(cmd_burst));
        if (cmd_burst == HBURST_INCR)
            cmd_beats = (cmd_len == '0) ? CW'(1) : cmd_len;
    end

    assign addr_acc = ahb.HTRANS[1] && ahb.HREADY;
    assign data_ok  = data_pend && ahb.HREADY && (ahb.HRESP == HRESP_OKAY);
    assign data_err = data_pend && !ahb.HREADY && (ahb.HRESP == HRESP_ERROR);

    // FIFO strobes are masked during reset so no word moves on a resetting edge.
    assign wr_ren  = HRESETN && ahb.HWRITE && addr_acc;
    assign rd_wen  = HRESETN && !ahb.HWRITE && data_ok;
    assign rd_data = ahb.HRDATA;

    assign ahb.HPROT     = 7'd0;
    assign ahb.HMASTLOCK = 1'b0;

    ahb_burst_master_addr_gen #(
        .ADDR_W (ADDR_W),
        .CW     (CW)
    ) u_addr_gen (
        .addr      (ahb.HADDR),
        .size      (ahb.HSIZE),
        .burst     (burst_q),
        .beats     (beats_q),
        .next_addr (next_addr),
        .cross_1k  (cross_1k)
    );

    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            state      <= S_IDLE;
            cmd_ready  <= 1'b0;
            done       <= 1'b0;
            done_err   <= 1'b0;
            done_beats <= '0;
            ahb.HADDR  <= '0;
            ahb.HBURST <= HBURST_SINGLE;
            ahb.HSIZE  <= HSIZE_BYTE;
            ahb.HTRANS <= HTRANS_IDLE;
            ahb.HWRITE <= 1'b0;
            ahb.HWDATA <= '0;
            burst_q    <= HBURST_SINGLE;
            beats_q    <= '0;
            addr_left  <= '0;
            beat_cnt   <= '0;
            data_pend  <= 1'b0;
        end else begin
            done     <= 1'b0;
            done_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready  <= 1'b0;
                        ahb.HADDR  <= cmd_addr;
                        ahb.HSIZE  <= cmd_size;
                        ahb.HBURST <= cmd_burst;
                        ahb.HWRITE <= cmd_write;
                        ahb.HTRANS <= HTRANS_NONSEQ;
                        burst_q    <= cmd_burst;
                        beats_q    <= cmd_beats;
                        addr_left  <= cmd_beats;
                        beat_cnt   <= '0;
                        state      <= S_ADDR;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (data_err) begin
                        ahb.HTRANS <= HTRANS_IDLE;
                        state      <= S_ERR;
                    end else if (ahb.HREADY) begin
                        data_pend <= 1'b1;
                        if (data_ok)
                            beat_cnt <= beat_cnt + CW'(1);
                        if (ahb.HWRITE)
                            ahb.HWDATA <= wr_data;
                        addr_left <= addr_left - CW'(1);
                        if (addr_left == CW'(1)) begin
                            ahb.HTRANS <= HTRANS_IDLE;
                            state      <= S_DATA;
                        end else begin
                            ahb.HADDR <= next_addr;
                            // Crossing 1 KB restarts the rest of the burst as undefined-length INCR.
                            if (cross_1k) begin
                                ahb.HTRANS <= HTRANS_NONSEQ;
                                ahb.HBURST <= HBURST_INCR;
                            end else begin
                                ahb.HTRANS <= HTRANS_SEQ;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (data_err) begin
                        state <= S_ERR;
                    end else if (ahb.HREADY) begin
                        data_pend  <= 1'b0;
                        done       <= 1'b1;
                        done_err   <= (ahb.HRESP == HRESP_ERROR);
                        done_beats <= beat_cnt + CW'(data_ok);
                        state      <= S_IDLE;
                    end
                end
                S_ERR: begin
                    if (ahb.HREADY) begin
                        data_pend  <= 1'b0;
                        done       <= 1'b1;
                        done_err   <= 1'b1;
                        done_beats <= beat_cnt;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
